cmd_frame_rx: RTL and testbench
===============================

# cmd_frame_rx

Command framer between the UART receiver and the command-execution/register-update logic of the pulse generator. It collects received bytes into a command buffer and recognises the CR,NL (8'h0d, 8'h0a) terminator. Each complete frame is presented to the executor through a valid/ready handshake. The block also handles overflow, receive errors, the inactivity timeout and the UART reset request.

## Interface
Parameters:
- BYTES, 16, maximum payload bytes per frame (terminator excluded)
- TIMEOUT_CYCLES, 50_000_000, sys_clk cycles of inactivity before a partial frame is abandoned (1 s at 50 MHz)
- LEN_BITS, 5, width of frame_len; must satisfy 2^LEN_BITS > BYTES

Ports:
- sys_clk  in  1  processing clock, 50 MHz
- rst_n  in  1  asynchronous, active-low reset
- received  in  1  one-cycle strobe from UART: rx_byte valid
- rx_byte  in  8  received byte
- recv_error  in  1  one-cycle strobe from UART: framing error
- frame_valid  out  1  complete frame available
- frame_ready  in  1  executor accepts frame
- frame_data  out  8*BYTES  payload; byte i at [8i+7:8i]; unused bytes zero
- frame_len  out  LEN_BITS  payload byte count, 1..BYTES
- uart_rst  out  1  one-cycle pulse requesting synchronous UART reset
- overflow_err  out  1  one-cycle pulse: payload exceeded BYTES
- timeout_err  out  1  one-cycle pulse: inactivity timeout
- drop_err  out  1  one-cycle pulse: byte dropped while a frame is held

## Operation
States:
- IDLE: buffer empty.
  - Byte other than CR → store at index 0, go to RECV.
  - CR → go to GOT_CR with empty payload.
- RECV: bytes are stored at index len, and len increments.
  - CR → go to GOT_CR; the CR is not stored.
- GOT_CR:
  - NL, len ≥ 1 → go to HOLD.
  - NL, len = 0 → go to IDLE silently.
  - CR → store the previous CR as data and stay in GOT_CR.
  - Any other byte → store the CR, then the byte, and go to RECV.
- HOLD: frame_valid=1. frame_data and frame_len are frozen.
  - frame_ready=1 → go to IDLE and clear the buffer.
  - Any byte received in HOLD is dropped and drop_err pulses.
- DISCARD: all bytes are ignored until the CR,NL sequence is seen, then go to IDLE.

Boundary conditions:
- Overflow: a data byte that would make len exceed BYTES → overflow_err and uart_rst pulse, the buffer is cleared, go to DISCARD. This also applies to a CR that becomes data.
- recv_error in IDLE, RECV, GOT_CR or DISCARD → clear the buffer, go to DISCARD. recv_error in HOLD is ignored.
- Timeout counter: reloads to TIMEOUT_CYCLES on every received.
  - It decrements only in RECV, GOT_CR and DISCARD; it is held in IDLE and HOLD.
  - On reaching 0 → timeout_err and uart_rst pulse, the buffer is cleared, go to IDLE.
- Simultaneous events:
  - received and counter reaching 0 on the same cycle: the byte wins and the counter reloads.
  - received and frame_ready in HOLD on the same cycle: the frame is consumed and the byte is dropped (drop_err).
- Buffer clearing: all buffer bytes are zeroed at every return to IDLE. Stale bytes never appear in frame_data.

## Timing
- Reset: all outputs are 0, state is IDLE, the buffer is zero, the counter is TIMEOUT_CYCLES. The reset is asynchronous.
- frame_valid rises on the cycle after the sys_clk edge that samples NL with received=1.
- frame_valid falls on the cycle after frame_ready is sampled high.
- Valid stays asserted with no timeout while frame_ready is low.
- Error pulses and uart_rst are registered and last exactly one cycle. They are asserted on the cycle after the causing event.
- Back-to-back received strobes on consecutive cycles must be accepted.

## Configuration
- CMD_FRAME_CHECKSUM_EN defined:
  - The last payload byte is the XOR of all preceding payload bytes.
  - On NL the checksum is compared. On a match → HOLD, with frame_len = len−1 and the checksum byte zeroed in frame_data.
  - On a mismatch, or len < 2 → csum_err pulses (extra 1-bit output port, present only with the macro) and the block returns to IDLE.
- Not defined: no checksum. Every frame with len ≥ 1 is delivered as received, and there is no csum_err port.

## Test plan
- Bytes 02,AA,BB,CC,DD,0D,0A, frame_ready held low → frame_valid=1, frame_len=5, frame_data[39:0]=DD_CC_BB_AA_02, upper bytes 0. Valid holds 1000 cycles. frame_ready=1 → valid=0 on the next cycle.
- 17 bytes 01, then 05,0D,0A → overflow_err and uart_rst pulse on the 17th byte, no frame_valid. Next frame 07,0D,0A → frame_len=1, data byte0=07.
- Bytes 04,0D,41,0D,0A → frame_len=3, payload 04,0D,41. A separate run with 0D,0A only → no frame_valid.
- Bytes 04,01 then idle, with TIMEOUT_CYCLES=100 → timeout_err and uart_rst pulse after 100 idle cycles, state IDLE. A new frame 05,0D,0A is delivered normally.
- Frame held, then byte 09 arrives on the same cycle frame_ready=1 → frame consumed, drop_err pulses once, buffer empty.
- recv_error mid-frame, then 33,0D,0A → no frame. Then 06,0D,0A → frame_len=1. rst_n low mid-frame → all outputs 0 immediately.

Source files
------------

// File: rtl/cmd_frame_rx.sv
// cmd_frame_rx: collects UART bytes into a command buffer, detects the CR,NL
// terminator and hands complete frames to the executor over valid/ready.
// Handles overflow, receive errors, inactivity timeout and UART reset pulses.
// Optional build macro CMD_FRAME_CHECKSUM_EN: the last payload byte is an XOR
// checksum of the preceding bytes; it is verified and stripped before delivery,
// and a csum_err output port is added.
module cmd_frame_rx #(
  parameter int BYTES          = 16,
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int LEN_BITS       = 5
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic                  received,
  input  logic [7:0]            rx_byte,
  input  logic                  recv_error,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic [8*BYTES-1:0]    frame_data,
  output logic [LEN_BITS-1:0]   frame_len,
  output logic                  uart_rst,
  output logic                  overflow_err,
  output logic                  timeout_err,
  output logic                  drop_err
`ifdef CMD_FRAME_CHECKSUM_EN
  ,
  output logic                  csum_err
`endif
);

  localparam logic [7:0] CR = 8'h0d;
  localparam logic [7:0] NL = 8'h0a;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_GOT_CR,
    S_HOLD,
    S_DISCARD,
    S_DISC_CR
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [7:0]          byte_buf [BYTES];
  logic [LEN_BITS-1:0] len;
  logic [LEN_BITS-1:0] idx1;
  logic [CNT_W-1:0]    cnt;

  logic                active;
  logic                tmo_hit;
  logic                wr0_en;
  logic [7:0]          wr0_dat;
  logic                wr1_en;
  logic [7:0]          wr1_dat;
  logic [1:0]          len_add;
  logic                clr;
  logic                ovf_nxt;
  logic                tmo_nxt;
  logic                drop_nxt;

  logic                uart_rst_q;
  logic                overflow_q;
  logic                timeout_q;
  logic                drop_q;

`ifdef CMD_FRAME_CHECKSUM_EN
  logic [7:0]          cks;
  logic                csum_nxt;
  logic                strip;
  logic                csum_q;
`endif

  // True when 'add' more data bytes still fit in the payload buffer.
  function automatic logic fits(input logic [LEN_BITS-1:0] cur, input int add);
    return (int'(cur) + add) <= BYTES;
  endfunction

  // The timeout counter only runs while a frame (or a discard) is in progress.
  assign active  = (state == S_RECV) || (state == S_GOT_CR) ||
                   (state == S_DISCARD) || (state == S_DISC_CR);
  assign tmo_hit = active && !received && (cnt == CNT_W'(1));
  assign idx1    = len + LEN_BITS'(1);

  // State register.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic plus buffer write and error-pulse requests.
  always_comb begin
    state_nxt = state;
    wr0_en    = 1'b0;
    wr0_dat   = rx_byte;
    wr1_en    = 1'b0;
    wr1_dat   = rx_byte;
    len_add   = 2'd0;
    clr       = 1'b0;
    ovf_nxt   = 1'b0;
    tmo_nxt   = 1'b0;
    drop_nxt  = 1'b0;
`ifdef CMD_FRAME_CHECKSUM_EN
    csum_nxt  = 1'b0;
    strip     = 1'b0;
`endif
    if (state != S_HOLD && recv_error) begin
      state_nxt = S_DISCARD;
      clr       = 1'b1;
    end else if (tmo_hit) begin
      state_nxt = S_IDLE;
      clr       = 1'b1;
      tmo_nxt   = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (received) begin
            if (rx_byte == CR) begin
              state_nxt = S_GOT_CR;
            end else begin
              wr0_en    = 1'b1;
              len_add   = 2'd1;
              state_nxt = S_RECV;
            end
          end
        end
        S_RECV: begin
          if (received) begin
            if (rx_byte == CR) begin
              state_nxt = S_GOT_CR;
            end else if (fits(len, 1)) begin
              wr0_en  = 1'b1;
              len_add = 2'd1;
            end else begin
              ovf_nxt   = 1'b1;
              clr       = 1'b1;
              state_nxt = S_DISCARD;
            end
          end
        end
        S_GOT_CR: begin
          if (received) begin
            if (rx_byte == NL) begin
              if (len == '0) begin
                state_nxt = S_IDLE;
                clr       = 1'b1;
              end else begin
`ifdef CMD_FRAME_CHECKSUM_EN
                if (int'(len) >= 2 && cks == 8'h00) begin
                  state_nxt = S_HOLD;
                  strip     = 1'b1;
                end else begin
                  csum_nxt  = 1'b1;
                  state_nxt = S_IDLE;
                  clr       = 1'b1;
                end
`else
                state_nxt = S_HOLD;
`endif
              end
            end else if (rx_byte == CR) begin
              // The earlier CR turns out to be data; the new CR stays pending.
              if (fits(len, 1)) begin
                wr0_en  = 1'b1;
                wr0_dat = CR;
                len_add = 2'd1;
              end else begin
                ovf_nxt   = 1'b1;
                clr       = 1'b1;
                state_nxt = S_DISCARD;
              end
            end else begin
              // Pending CR and the new byte both land in one cycle.
              if (fits(len, 2)) begin
                wr0_en    = 1'b1;
                wr0_dat   = CR;
                wr1_en    = 1'b1;
                len_add   = 2'd2;
                state_nxt = S_RECV;
              end else begin
                ovf_nxt   = 1'b1;
                clr       = 1'b1;
                state_nxt = S_DISCARD;
              end
            end
          end
        end
        S_HOLD: begin
          if (frame_ready) begin
            state_nxt = S_IDLE;
            clr       = 1'b1;
          end
          if (received) drop_nxt = 1'b1;
        end
        S_DISCARD: begin
          if (received && rx_byte == CR) state_nxt = S_DISC_CR;
        end
        S_DISC_CR: begin
          if (received) begin
            if (rx_byte == NL) begin
              state_nxt = S_IDLE;
              clr       = 1'b1;
            end else if (rx_byte != CR) begin
              state_nxt = S_DISCARD;
            end
          end
        end
        default: begin
          state_nxt = S_IDLE;
          clr       = 1'b1;
        end
      endcase
    end
  end

  // Payload buffer: writes at len (and len+1 for a deferred CR), zeroed on clear.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BYTES; i++) byte_buf[i] <= 8'h00;
    end else if (clr) begin
      for (int i = 0; i < BYTES; i++) byte_buf[i] <= 8'h00;
    end else begin
      for (int i = 0; i < BYTES; i++) begin
        if (wr0_en && len == LEN_BITS'(i)) byte_buf[i] <= wr0_dat;
        if (wr1_en && idx1 == LEN_BITS'(i)) byte_buf[i] <= wr1_dat;
`ifdef CMD_FRAME_CHECKSUM_EN
        if (strip && (len - LEN_BITS'(1)) == LEN_BITS'(i)) byte_buf[i] <= 8'h00;
`endif
      end
    end
  end

  // Payload length counter.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n)   len <= '0;
    else if (clr) len <= '0;
`ifdef CMD_FRAME_CHECKSUM_EN
    else if (strip) len <= len - LEN_BITS'(1);
`endif
    else          len <= len + LEN_BITS'(len_add);
  end

  // Inactivity counter: reloads on any byte, runs only in active states.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n)                   cnt <= CNT_LOAD;
    else if (received || tmo_hit) cnt <= CNT_LOAD;
    else if (active)              cnt <= cnt - CNT_W'(1);
  end

  // Registered one-cycle error and UART reset pulses.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      uart_rst_q <= 1'b0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      uart_rst_q <= ovf_nxt | tmo_nxt;
      overflow_q <= ovf_nxt;
      timeout_q  <= tmo_nxt;
      drop_q     <= drop_nxt;
    end
  end

`ifdef CMD_FRAME_CHECKSUM_EN
  // Running XOR of stored payload bytes and the checksum-error pulse.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cks    <= 8'h00;
      csum_q <= 1'b0;
    end else begin
      csum_q <= csum_nxt;
      if (clr) cks <= 8'h00;
      else     cks <= cks ^ (wr0_en ? wr0_dat : 8'h00) ^ (wr1_en ? wr1_dat : 8'h00);
    end
  end

  assign csum_err = csum_q;
`endif

  for (genvar g = 0; g < BYTES; g++) begin : g_data
    assign frame_data[8*g +: 8] = byte_buf[g];
  end

  assign frame_valid  = (state == S_HOLD);
  assign frame_len    = len;
  assign uart_rst     = uart_rst_q;
  assign overflow_err = overflow_q;
  assign timeout_err  = timeout_q;
  assign drop_err     = drop_q;

endmodule

// File: tb/tb_cmd_frame_rx.sv
// Scoreboard bench for cmd_frame_rx: expected frames and error pulses are
// queued by the stimulus and popped by an independent monitor.
module tb_cmd_frame_rx;
  localparam int BYTES = 16;
  localparam int TMO   = 100;
  localparam int LB    = 5;

  logic                sys_clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                received = 1'b0;
  logic [7:0]          rx_byte = 8'h00;
  logic                recv_error = 1'b0;
  logic                frame_valid;
  logic                frame_ready = 1'b0;
  logic [8*BYTES-1:0]  frame_data;
  logic [LB-1:0]       frame_len;
  logic                uart_rst;
  logic                overflow_err;
  logic                timeout_err;
  logic                drop_err;
`ifdef CMD_FRAME_CHECKSUM_EN
  logic                csum_err;
`endif

  cmd_frame_rx #(.BYTES(BYTES), .TIMEOUT_CYCLES(TMO), .LEN_BITS(LB)) dut (
    .sys_clk      (sys_clk),
    .rst_n        (rst_n),
    .received     (received),
    .rx_byte      (rx_byte),
    .recv_error   (recv_error),
    .frame_valid  (frame_valid),
    .frame_ready  (frame_ready),
    .frame_data   (frame_data),
    .frame_len    (frame_len),
    .uart_rst     (uart_rst),
    .overflow_err (overflow_err),
    .timeout_err  (timeout_err),
    .drop_err     (drop_err)
`ifdef CMD_FRAME_CHECKSUM_EN
    ,
    .csum_err     (csum_err)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [LB-1:0]      len;
    logic [8*BYTES-1:0] data;
  } frame_t;

  frame_t     exp_frames[$];
  logic [3:0] exp_events[$];   // {uart_rst, overflow_err, timeout_err, drop_err}
  int         checks = 0;
  int         failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_frame(input logic [LB-1:0] l, input logic [8*BYTES-1:0] d);
    frame_t f;
    f.len  = l;
    f.data = d;
    exp_frames.push_back(f);
  endtask

  // Monitor: compare each new frame and each error pulse cycle with the queues.
  frame_t     mon_f;
  logic [3:0] mon_ev;
  logic [3:0] mon_exp;
  logic       prev_valid = 1'b0;
  always @(negedge sys_clk) begin
    if (rst_n) begin
      if (frame_valid && !prev_valid) begin
        if (exp_frames.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_frame actual_len=%0d actual_data=%0h required=none", frame_len, frame_data);
        end else begin
          mon_f = exp_frames.pop_front();
          check("frame_len", frame_len, mon_f.len);
          check("frame_data", frame_data, mon_f.data);
        end
      end
      mon_ev = {uart_rst, overflow_err, timeout_err, drop_err};
      if (mon_ev != 4'b0000) begin
        if (exp_events.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pulse actual=%b required=none", mon_ev);
        end else begin
          mon_exp = exp_events.pop_front();
          check("pulse", mon_ev, mon_exp);
        end
      end
    end
    prev_valid <= frame_valid;
  end

  // One byte strobe; consecutive calls give back-to-back strobes.
  task automatic send(input logic [7:0] b);
    received = 1'b1;
    rx_byte  = b;
    @(negedge sys_clk);
    received = 1'b0;
  endtask

  // Sends n bytes from vec, most significant byte first.
  task automatic send_n(input int n, input logic [191:0] vec);
    for (int i = n - 1; i >= 0; i--) send(vec[8*i +: 8]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic accept();
    frame_ready = 1'b1;
    @(negedge sys_clk);
    frame_ready = 1'b0;
    check("valid_fall", frame_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int drops;

    // Reset state
    idle(3);
    check("reset_ctrl", {frame_valid, uart_rst, overflow_err, timeout_err, drop_err}, 5'b0);
    check("reset_len", frame_len, 0);
    check("reset_data", frame_data, 0);
    rst_n = 1'b1;
    idle(2);

    // Basic frame held for 1000 cycles, recv_error while held is ignored
    push_frame(5, 128'hDD_CC_BB_AA_02);
    send_n(7, 56'h02_AA_BB_CC_DD_0D_0A);
    check("t1_valid_rise", frame_valid, 1'b1);
    drops = 0;
    for (int c = 0; c < 1000; c++) begin
      recv_error = (c == 500);
      @(negedge sys_clk);
      if (!frame_valid) drops++;
    end
    recv_error = 1'b0;
    check("t1_valid_hold", drops, 0);
    check("t1_data_frozen", frame_data, 128'hDD_CC_BB_AA_02);
    accept();

    // Overflow on the 17th byte, rest discarded up to CR,NL
    exp_events.push_back(4'b1100);
    repeat (17) send(8'h01);
    send_n(3, 24'h05_0D_0A);
    idle(3);
    check("t2_no_frame", frame_valid, 1'b0);
    push_frame(1, 128'h07);
    send_n(3, 24'h07_0D_0A);
    check("t2_valid", frame_valid, 1'b1);
    accept();

    // Lone CR becomes data; empty CR,NL frame is silent
    push_frame(3, 128'h41_0D_04);
    send_n(5, 40'h04_0D_41_0D_0A);
    check("t3_valid", frame_valid, 1'b1);
    accept();
    send_n(2, 16'h0D_0A);
    idle(5);
    check("t3_empty_frame", frame_valid, 1'b0);

    // Inactivity timeout after exactly TMO idle cycles
    exp_events.push_back(4'b1010);
    send_n(2, 16'h04_01);
    k = 0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge sys_clk);
      if (timeout_err) begin
        k = c;
        break;
      end
    end
    check("t4_timeout_cycles", k, TMO);
    push_frame(1, 128'h05);
    send_n(3, 24'h05_0D_0A);
    check("t4_valid", frame_valid, 1'b1);
    accept();

    // Byte on the same cycle as frame_ready: consumed and dropped
    push_frame(2, 128'h22_11);
    send_n(4, 32'h11_22_0D_0A);
    check("t5_valid", frame_valid, 1'b1);
    exp_events.push_back(4'b0001);
    frame_ready = 1'b1;
    received    = 1'b1;
    rx_byte     = 8'h09;
    @(negedge sys_clk);
    frame_ready = 1'b0;
    received    = 1'b0;
    check("t5_valid_fall", frame_valid, 1'b0);
    send_n(2, 16'h0D_0A);
    idle(5);
    check("t5_buffer_empty", frame_valid, 1'b0);
    push_frame(1, 128'h08);
    send_n(3, 24'h08_0D_0A);
    check("t5_valid_next", frame_valid, 1'b1);
    accept();

    // Full-size frame with embedded CR and NL data bytes
    push_frame(16, 128'h100F0E0D0C0B0A09_0807060504030201);
    for (int b = 1; b <= 16; b++) send(8'(b));
    send_n(2, 16'h0D_0A);
    check("t6_valid", frame_valid, 1'b1);
    accept();

    // Receive error mid-frame discards up to CR,NL
    send_n(2, 16'h01_02);
    recv_error = 1'b1;
    @(negedge sys_clk);
    recv_error = 1'b0;
    send_n(3, 24'h33_0D_0A);
    idle(5);
    check("t7_no_frame", frame_valid, 1'b0);
    push_frame(1, 128'h06);
    send_n(3, 24'h06_0D_0A);
    check("t7_valid", frame_valid, 1'b1);
    accept();

    // Asynchronous reset while a frame is held and while one is partial
    push_frame(2, 128'hA2_A1);
    send_n(4, 32'hA1_A2_0D_0A);
    check("t8_valid", frame_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t8_rst_ctrl", {frame_valid, uart_rst, overflow_err, timeout_err, drop_err}, 5'b0);
    check("t8_rst_len", frame_len, 0);
    check("t8_rst_data", frame_data, 0);
    @(negedge sys_clk);
    rst_n = 1'b1;
    send_n(2, 16'h55_66);
    #2 rst_n = 1'b0;
    #1;
    check("t8_rst_partial_len", frame_len, 0);
    check("t8_rst_partial_data", frame_data, 0);
    @(negedge sys_clk);
    rst_n = 1'b1;
    idle(5);

    check("frames_outstanding", exp_frames.size(), 0);
    check("pulses_outstanding", exp_events.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
